bpred_ctrl: RTL

Branch-predictor controller for the 5-stage pipeline. It owns the 2-bit saturating-counter pattern history table and supplies the fetch-stage prediction. It retrains the table from branches resolved in MEM, and on a mispredict it issues the PC redirect and the IF/ID and ID/EX flushes. After reset, or on request, it sweeps the table to its initial state while holding fetch.

---
 rtl/bpred_ctrl_pkg.sv | 23 ++
 rtl/bpred_pht.sv | 21 ++
 rtl/bpred_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bpred_ctrl_pkg.sv
// rtl/bpred_ctrl_pkg.sv - shared FSM encoding, counter constants and saturating update for bpred_ctrl
package bpred_ctrl_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic [1:0] CNT_SNT = 2'd0;
  localparam logic [1:0] CNT_WNT = 2'd1;
  localparam logic [1:0] CNT_WT  = 2'd2;
  localparam logic [1:0] CNT_ST  = 2'd3;

  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    case (cnt)
      CNT_SNT: return taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: return taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  return taken ? CNT_ST  : CNT_WNT;
      default: return taken ? CNT_ST  : CNT_WT;
    endcase
  endfunction

endpackage

// File: rtl/bpred_pht.sv
// rtl/bpred_pht.sv - pattern history table storage: one async read port, one sync write port, no reset
module bpred_pht #(
  parameter int INDEX_W = 10
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] waddr_i,
  input  logic [1:0]         wdata_i,
  input  logic [INDEX_W-1:0] raddr_i,
  output logic [1:0]         rdata_o
);

  logic [1:0] mem_q [2**INDEX_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bpred_ctrl.sv
// rtl/bpred_ctrl.sv - branch predictor controller: PHT clear sweep, training, mispredict redirect
// Optional branch/mispredict statistics counters with BPRED_STATS_EN.
module bpred_ctrl
  import bpred_ctrl_pkg::*;
#(
  parameter int         INDEX_W  = 10,
  parameter logic [1:0] INIT_CNT = CNT_WNT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pcIF,
  output logic        predTaken,
  output logic [1:0]  predCnt,
  input  logic        BtoMe,
  input  logic        zerotoMe,
  input  logic        predTakenMe,
  input  logic [1:0]  predCntMe,
  input  logic [31:0] pcNewtoMe,
  input  logic [31:0] BpctoMe,
  input  logic        flushReq,
  output logic        stallIF,
  output logic        redirect,
  output logic [31:0] correctPc,
  output logic        flushIFID,
  output logic        flushIDEX,
`ifdef BPRED_STATS_EN
  output logic [31:0] branchCnt,
  output logic [31:0] mispredCnt,
`endif
  output logic        busy
);

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] sweep_idx_q, sweep_idx_d;
  logic               redirect_q;
  logic [31:0]        correct_pc_q, correct_pc_d;

  logic               taken, mispred;
  logic [31:0]        upd_pc;
  logic               pht_we;
  logic [INDEX_W-1:0] pht_waddr;
  logic [1:0]         pht_wdata, pht_rdata;
  logic               unused_bits;

  assign taken   = BtoMe & zerotoMe;
  assign mispred = BtoMe & (taken != predTakenMe);
  assign upd_pc  = pcNewtoMe - 32'd4;
  assign unused_bits = ^{pcIF[31:INDEX_W+2], pcIF[1:0], upd_pc[31:INDEX_W+2], upd_pc[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  // flushReq overrides everything, including an in-progress sweep
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    unique case (state_q)
      ST_CLEAR: begin
        sweep_idx_d = sweep_idx_q + 1'b1;
        if (sweep_idx_q == '1) state_d = ST_RUN;
      end
      default: ;
    endcase
    if (flushReq) begin
      state_d     = ST_CLEAR;
      sweep_idx_d = '0;
    end
  end

  always_comb begin
    busy      = (state_q == ST_CLEAR);
    stallIF   = busy;
    predCnt   = busy ? 2'b00 : pht_rdata;
    predTaken = busy ? 1'b0  : pht_rdata[1];
  end

  // The sweep owns the write port; training writes during CLEAR are dropped
  always_comb begin
    pht_we    = 1'b0;
    pht_waddr = sweep_idx_q;
    pht_wdata = INIT_CNT;
    if (state_q == ST_CLEAR) begin
      pht_we = 1'b1;
    end else if (BtoMe) begin
      pht_we    = 1'b1;
      pht_waddr = upd_pc[INDEX_W+1:2];
      pht_wdata = cnt_next(predCntMe, taken);
    end
  end

  bpred_pht #(.INDEX_W(INDEX_W)) u_pht (
    .clk     (clk),
    .we_i    (pht_we),
    .waddr_i (pht_waddr),
    .wdata_i (pht_wdata),
    .raddr_i (pcIF[INDEX_W+1:2]),
    .rdata_o (pht_rdata)
  );

  always_comb begin
    correct_pc_d = correct_pc_q;
    if (mispred) correct_pc_d = taken ? BpctoMe : pcNewtoMe;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_q   <= 1'b0;
      correct_pc_q <= '0;
    end else begin
      redirect_q   <= mispred;
      correct_pc_q <= correct_pc_d;
    end
  end

  assign redirect  = redirect_q;
  assign flushIFID = redirect_q;
  assign flushIDEX = redirect_q;
  assign correctPc = correct_pc_q;

`ifdef BPRED_STATS_EN
  logic [31:0] branch_cnt_q, mispred_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (BtoMe)   branch_cnt_q  <= branch_cnt_q + 32'd1;
      if (mispred) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign branchCnt  = branch_cnt_q;
  assign mispredCnt = mispred_cnt_q;
`endif

endmodule
